// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - cook-time BCD MM:SS countdown feeding the magnetron controller
//
// Keypad digits shift into a 4-digit BCD MM:SS register while the timer is not
// running. While enable (mag_on) is high and time is non-zero, a prescaler
// counts TICKS_PER_SEC clocks per second and the time decrements with BCD
// borrows. timer_done is high whenever the time is 00:00.
//
// Optional feature macro: COOK_TIMER_BEEP_EN
//   defined   -> beep output present, high for BEEP_SECS seconds after RUN hits 00:00
//   undefined -> no beep port, no beep counter
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active-high
//   clearn       in   1  synchronous clear of time, prescaler and beep, active-low
//   digit_valid  in   1  keypad strobe
//   digit        in   4  keypad value, BCD 0-9 (values >9 are ignored)
//   enable       in   1  count enable (mag_on)
//   sec_ones     out  4  BCD seconds units
//   sec_tens     out  4  BCD seconds tens
//   min_ones     out  4  BCD minutes units
//   min_tens     out  4  BCD minutes tens
//   tick         out  1  one-cycle pulse per 1-second decrement
//   timer_done   out  1  high while time == 00:00
//   beep         out  1  end-of-cook indicator (COOK_TIMER_BEEP_EN only)

module cook_timer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       enable,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       tick,
    output logic       timer_done
`ifdef COOK_TIMER_BEEP_EN
    ,
    output logic       beep
`endif
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN
    } mode_t;

    mode_t         mode;
    logic [15:0]   time_q;
    logic [15:0]   time_d;
    logic [15:0]   time_dec;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_d;
    logic          sec_wrap;
    logic          digit_ok;

    logic [3:0] so;
    logic [3:0] st;
    logic [3:0] mo;
    logic [3:0] mt;
    logic [3:0] dec_so;
    logic [3:0] dec_st;
    logic [3:0] dec_mo;
    logic [3:0] dec_mt;

    assign {mt, mo, st, so} = time_q;
    assign {min_tens, min_ones, sec_tens, sec_ones} = time_q;

    // Mode is a pure function of the held time and the live enable, so RUN
    // starts counting on the very first cycle enable is seen.
    always_comb begin
        mode = IDLE;
        if (time_q != 16'h0000) begin
            mode = enable ? RUN : ARMED;
        end
    end

    assign sec_wrap = (presc_q == PRESC_LAST);
    assign digit_ok = clearn && !enable && digit_valid && (digit <= 4'd9);

    // BCD decrement with borrow chain; seconds tens wraps to 5 so an entered
    // 6-9 in the tens place simply counts down as extra seconds.
    always_comb begin
        dec_so = so;
        dec_st = st;
        dec_mo = mo;
        dec_mt = mt;
        if (so != 4'd0) begin
            dec_so = so - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (st != 4'd0) begin
                dec_st = st - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (mo != 4'd0) begin
                    dec_mo = mo - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = mt - 4'd1;
                end
            end
        end
        time_dec = {dec_mt, dec_mo, dec_st, dec_so};
    end

    // Next-state: clear > count > digit entry. The prescaler is only touched
    // in RUN, so pausing keeps the partial second.
    always_comb begin
        time_d  = time_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (!clearn) begin
            time_d  = 16'h0000;
            presc_d = '0;
        end else if (mode == RUN) begin
            if (sec_wrap) begin
                presc_d = '0;
                time_d  = time_dec;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (digit_ok) begin
            time_d = {time_q[11:0], digit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q     <= 16'h0000;
            presc_q    <= '0;
            tick       <= 1'b0;
            timer_done <= 1'b1;
        end else begin
            time_q     <= time_d;
            presc_q    <= presc_d;
            tick       <= tick_d;
            timer_done <= (time_d == 16'h0000);
        end
    end

`ifdef COOK_TIMER_BEEP_EN
    localparam int BEEP_CYCLES = BEEP_SECS * TICKS_PER_SEC;
    localparam int BW = $clog2(BEEP_CYCLES);

    logic [BW-1:0] beep_cnt;
    logic          hit_zero;

    // The final decrement of a run, i.e. the edge on which RUN lands on 00:00.
    assign hit_zero = clearn && (mode == RUN) && sec_wrap && (time_dec == 16'h0000);

    // beep_cnt counts the remaining high cycles after the first; it runs
    // regardless of enable once started.
    always_ff @(posedge clk) begin
        if (rst || !clearn || digit_ok) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (hit_zero) begin
            beep     <= 1'b1;
            beep_cnt <= BW'(BEEP_CYCLES - 1);
        end else if (beep) begin
            if (beep_cnt == '0) begin
                beep <= 1'b0;
            end else begin
                beep_cnt <= beep_cnt - 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cook_timer.sv
// tb/tb_cook_timer.sv - scoreboard bench for cook_timer (TICKS_PER_SEC=4, BEEP_SECS=2)

module tb_cook_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] digit;
    logic       enable;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       tick;
    logic       timer_done;
    logic       beep_w;

`ifdef COOK_TIMER_BEEP_EN
    localparam bit HAS_BEEP = 1'b1;
`else
    localparam bit HAS_BEEP = 1'b0;
    assign beep_w = 1'b0;
`endif

    cook_timer #(
        .TICKS_PER_SEC(4),
        .BEEP_SECS    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clearn     (clearn),
        .digit_valid(digit_valid),
        .digit      (digit),
        .enable     (enable),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .tick       (tick),
        .timer_done (timer_done)
`ifdef COOK_TIMER_BEEP_EN
        ,
        .beep       (beep_w)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] t;
        logic        tk;
        logic        dn;
        logic        bp;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [15:0] obs;
        obs = {min_tens, min_ones, sec_tens, sec_ones};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc || obs !== e.t || tick !== e.tk ||
                timer_done !== e.dn || beep_w !== e.bp) begin
                errors = errors + 1;
                $display("FAIL %s @cyc %0d: got time=%h tick=%b done=%b beep=%b, want time=%h tick=%b done=%b beep=%b",
                         e.nm, cyc, obs, tick, timer_done, beep_w, e.t, e.tk, e.dn, e.bp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic want(input int d, input logic [15:0] t, input logic tk,
                        input logic dn, input logic bp, input string nm);
        exp_t e;
        e.cyc = cyc + d;
        e.t   = t;
        e.tk  = tk;
        e.dn  = dn;
        e.bp  = bp;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic key(input logic [3:0] v);
        digit_valid = 1'b1;
        digit       = v;
        step(1);
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic clear_pulse(input string nm);
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        want(0, 16'h0000, 1'b0, 1'b1, 1'b0, nm);
    endtask

    initial begin
        rst         = 1'b1;
        clearn      = 1'b1;
        digit_valid = 1'b0;
        digit       = 4'd0;
        enable      = 1'b0;

        step(1);
        rst = 1'b0;
        want(0, 16'h0000, 1'b0, 1'b1, 1'b0, "reset");
        checks = checks + 1;
        if (timer_done !== 1'b1 || tick !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL direct_reset: done=%b tick=%b", timer_done, tick);
        end

        key(4'd1);
        want(0, 16'h0001, 1'b0, 1'b0, 1'b0, "key1");
        key(4'd3);
        want(0, 16'h0013, 1'b0, 1'b0, 1'b0, "key3");
        key(4'd0);
        want(0, 16'h0130, 1'b0, 1'b0, 1'b0, "key0_0130");
        key(4'd12);
        want(0, 16'h0130, 1'b0, 1'b0, 1'b0, "key12_ignored");
        clear_pulse("clear_after_entry");

        key(4'd2);
        want(0, 16'h0002, 1'b0, 1'b0, 1'b0, "load_0002");
        checks = checks + 1;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0002) begin
            errors = errors + 1;
            $display("FAIL direct_load_0002: time=%h", {min_tens, min_ones, sec_tens, sec_ones});
        end
        enable = 1'b1;
        want(3,  16'h0002, 1'b0, 1'b0, 1'b0,     "pre_tick1");
        want(4,  16'h0001, 1'b1, 1'b0, 1'b0,     "tick1");
        want(5,  16'h0001, 1'b0, 1'b0, 1'b0,     "tick1_one_cycle");
        want(8,  16'h0000, 1'b1, 1'b1, HAS_BEEP, "tick2_done");
        want(9,  16'h0000, 1'b0, 1'b1, HAS_BEEP, "after_done");
        want(12, 16'h0000, 1'b0, 1'b1, HAS_BEEP, "no_more_ticks");
        step(12);
        enable = 1'b0;

        key(4'd1);
        want(0, 16'h0001, 1'b0, 1'b0, 1'b0, "key_clears_beep");
        key(4'd0);
        key(4'd0);
        want(0, 16'h0100, 1'b0, 1'b0, 1'b0, "load_0100");
        enable = 1'b1;
        want(3,  16'h0100, 1'b0, 1'b0, 1'b0, "pre_borrow");
        want(4,  16'h0059, 1'b1, 1'b0, 1'b0, "borrow_0059");
        want(16, 16'h0059, 1'b0, 1'b0, 1'b0, "paused_hold");
        want(17, 16'h0059, 1'b0, 1'b0, 1'b0, "resume_1");
        want(18, 16'h0058, 1'b1, 1'b0, 1'b0, "resume_tick_0058");
        step(6);
        enable = 1'b0;
        step(10);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        clear_pulse("clear_after_pause");

        key(4'd4);
        key(4'd5);
        want(0, 16'h0045, 1'b0, 1'b0, 1'b0, "load_0045");
        enable = 1'b1;
        step(2);
        clearn      = 1'b0;
        digit_valid = 1'b1;
        digit       = 4'd7;
        step(1);
        clearn      = 1'b1;
        want(0, 16'h0000, 1'b0, 1'b1, 1'b0, "clear_beats_digit");
        digit       = 4'd3;
        step(1);
        digit_valid = 1'b0;
        want(0, 16'h0000, 1'b0, 1'b1, 1'b0, "digit_ignored_enable");
        want(5, 16'h0000, 1'b0, 1'b1, 1'b0, "idle_enable_no_change");
        step(5);
        enable = 1'b0;

        key(4'd5);
        want(0, 16'h0005, 1'b0, 1'b0, 1'b0, "load_0005");
        enable      = 1'b1;
        digit_valid = 1'b1;
        digit       = 4'd9;
        want(1, 16'h0005, 1'b0, 1'b0, 1'b0, "run_digit_ignored");
        want(4, 16'h0004, 1'b1, 1'b0, 1'b0, "tick_beats_strobe");
        step(4);
        digit_valid = 1'b0;
        enable      = 1'b0;
        clear_pulse("clear_after_strobe");

        key(4'd1);
        key(4'd0);
        key(4'd0);
        key(4'd0);
        want(0, 16'h1000, 1'b0, 1'b0, 1'b0, "load_1000");
        enable = 1'b1;
        want(4, 16'h0959, 1'b1, 1'b0, 1'b0, "borrow_0959");
        step(4);
        enable = 1'b0;
        key(4'd1);
        key(4'd2);
        key(4'd3);
        key(4'd4);
        want(0, 16'h1234, 1'b0, 1'b0, 1'b0, "load_1234");
        key(4'd5);
        want(0, 16'h2345, 1'b0, 1'b0, 1'b0, "shift_discard");
        checks = checks + 1;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h2345) begin
            errors = errors + 1;
            $display("FAIL direct_shift_discard: time=%h", {min_tens, min_ones, sec_tens, sec_ones});
        end
        clear_pulse("clear_after_shift");
        checks = checks + 1;
        if (timer_done !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL direct_clear_done: done=%b", timer_done);
        end

`ifdef COOK_TIMER_BEEP_EN
        key(4'd1);
        enable = 1'b1;
        want(3,  16'h0001, 1'b0, 1'b0, 1'b0, "beep_pre");
        want(4,  16'h0000, 1'b1, 1'b1, 1'b1, "beep_rise");
        want(11, 16'h0000, 1'b0, 1'b1, 1'b1, "beep_last");
        want(12, 16'h0000, 1'b0, 1'b1, 1'b0, "beep_fall");
        step(12);
        enable = 1'b0;
        key(4'd1);
        enable = 1'b1;
        want(4, 16'h0000, 1'b1, 1'b1, 1'b1, "beep2_rise");
        step(4);
        enable = 1'b0;
        want(2, 16'h0000, 1'b0, 1'b1, 1'b1, "beep2_cycle3");
        step(2);
        key(4'd2);
        want(0, 16'h0002, 1'b0, 1'b0, 1'b0, "beep_cancel_digit");
`endif

        for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: never checked, due cyc %0d, now cyc %0d", e.nm, e.cyc, cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
